// File: rtl/regfile_wb_arbiter.sv
// Round-robin writeback arbiter for a single register-file write port, with a
// registered write stage, same-cycle read forwarding and a saturating stall counter.
module regfile_wb_arbiter #(
   parameter int STALL_CNT_W = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   hold,
   input  logic                   clr_stats,
   input  logic                   req0_valid,
   output logic                   req0_ready,
   input  logic [4:0]             req0_addr,
   input  logic [31:0]            req0_data,
   input  logic                   req1_valid,
   output logic                   req1_ready,
   input  logic [4:0]             req1_addr,
   input  logic [31:0]            req1_data,
   output logic                   wr_ena,
   output logic [4:0]             wr_addr,
   output logic [31:0]            wr_data,
   input  logic [4:0]             rd_addr0,
   input  logic [4:0]             rd_addr1,
   input  logic [31:0]            rf_rd_data0,
   input  logic [31:0]            rf_rd_data1,
   output logic [31:0]            fwd_data0,
   output logic [31:0]            fwd_data1,
   output logic [STALL_CNT_W-1:0] stall_count
);

   localparam logic [STALL_CNT_W-1:0] CNT_ONE = 1;

   logic                   last_grant_q, last_grant_d;
   logic                   wr_ena_q, wr_ena_d;
   logic [4:0]             wr_addr_q, wr_addr_d;
   logic [31:0]            wr_data_q, wr_data_d;
   logic [STALL_CNT_W-1:0] stall_q, stall_d;
   logic                   gnt0, gnt1, stalled;

   // On a tie, the requester that did not win last time is granted.
   always_comb begin
      // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
      gnt0 = 1'b0;
      gnt1 = 1'b0;
      if (!hold) begin
         if (req0_valid && req1_valid) begin
            gnt0 = last_grant_q;
            gnt1 = !last_grant_q;
         end else begin
            gnt0 = req0_valid;
            gnt1 = req1_valid;
         end
      end
   end

   assign req0_ready = gnt0;
   assign req1_ready = gnt1;
   assign stalled    = (req0_valid && !gnt0) || (req1_valid && !gnt1);

   always_comb begin
      last_grant_d = last_grant_q;
      wr_ena_d     = 1'b0;
      wr_addr_d    = wr_addr_q;
      wr_data_d    = wr_data_q;
      if (gnt0) begin
         last_grant_d = 1'b0;
         if (req0_addr != 5'd0) begin
            wr_ena_d  = 1'b1;
            wr_addr_d = req0_addr;
            wr_data_d = req0_data;
         end
      end else if (gnt1) begin
         last_grant_d = 1'b1;
         if (req1_addr != 5'd0) begin
            wr_ena_d  = 1'b1;
            wr_addr_d = req1_addr;
            wr_data_d = req1_data;
         end
      end

      if (clr_stats) begin
         stall_d = '0;
      end else if (stalled && (stall_q != '1)) begin
         stall_d = stall_q + CNT_ONE;
      end else begin
         stall_d = stall_q;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      if (!rst) begin
         last_grant_q <= 1'b1;
         wr_ena_q     <= 1'b0;
         wr_addr_q    <= 5'd0;
         wr_data_q    <= 32'd0;
         stall_q      <= '0;
      end else begin
         last_grant_q <= last_grant_d;
         wr_ena_q     <= wr_ena_d;
         wr_addr_q    <= wr_addr_d;
         wr_data_q    <= wr_data_d;
         stall_q      <= stall_d;
      end
   end

   assign wr_ena      = wr_ena_q;
   assign wr_addr     = wr_addr_q;
   assign wr_data     = wr_data_q;
   assign stall_count = stall_q;

   assign fwd_data0 = (wr_ena_q && (wr_addr_q == rd_addr0) && (rd_addr0 != 5'd0)) ? wr_data_q : rf_rd_data0;
   assign fwd_data1 = (wr_ena_q && (wr_addr_q == rd_addr1) && (rd_addr1 != 5'd0)) ? wr_data_q : rf_rd_data1;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: directed scenarios followed by
// randomized traffic, all compared against a behavioural writeback model.
module tb_regfile_wb_arbiter;

   localparam int CW = 4;
   localparam int CNT_MAX = (1 << CW) - 1;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          hold = 1'b0, clr_stats = 1'b0;
   logic          req0_valid = 1'b0, req1_valid = 1'b0;
   logic          req0_ready, req1_ready;
   logic [4:0]    req0_addr = '0, req1_addr = '0;
   logic [31:0]   req0_data = '0, req1_data = '0;
   logic          wr_ena;
   logic [4:0]    wr_addr;
   logic [31:0]   wr_data;
   logic [4:0]    rd_addr0 = '0, rd_addr1 = '0;
   logic [31:0]   rf_rd_data0 = '0, rf_rd_data1 = '0;
   logic [31:0]   fwd_data0, fwd_data1;
   logic [CW-1:0] stall_count;

   regfile_wb_arbiter #(.STALL_CNT_W(CW)) dut (
      .clk(clk), .rst(rst), .hold(hold), .clr_stats(clr_stats),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_addr(req0_addr), .req0_data(req0_data),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_addr(req1_addr), .req1_data(req1_data),
      .wr_ena(wr_ena), .wr_addr(wr_addr), .wr_data(wr_data),
      .rd_addr0(rd_addr0), .rd_addr1(rd_addr1), .rf_rd_data0(rf_rd_data0), .rf_rd_data1(rf_rd_data1),
      .fwd_data0(fwd_data0), .fwd_data1(fwd_data1), .stall_count(stall_count)
   );

   always #5 clk = ~clk;

   int n_pass = 0;
   int n_total = 0;

   // Behavioural model: who won last, the pending committed write, the stall tally
   // and an architectural register file that absorbs each committed write.
   int          m_last;
   logic        m_ena;
   logic [4:0]  m_addr;
   logic [31:0] m_data;
   int          m_stall;
   logic [31:0] rf_mem [32];
   bit          use_mem = 1'b0;
   int          exp_g;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   task automatic model_reset();
      m_last  = 1;
      m_ena   = 1'b0;
      m_addr  = '0;
      m_data  = '0;
      m_stall = 0;
   endtask

   task automatic do_reset();
      rst = 1'b0;
      hold = 1'b0; clr_stats = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
      @(negedge clk);
      check("rst_wr_ena", {31'd0, wr_ena}, 32'd0);
      check("rst_wr_addr", {27'd0, wr_addr}, 32'd0);
      check("rst_wr_data", wr_data, 32'd0);
      check("rst_stall", {28'd0, stall_count}, 32'd0);
      rst = 1'b1;
      model_reset();
      @(negedge clk);
   endtask

   // One clock: drive at the falling edge, check mid-cycle, update the model at the rising edge.
   task automatic step(input logic h, input logic c,
                       input logic v0, input logic [4:0] a0, input logic [31:0] d0,
                       input logic v1, input logic [4:0] a1, input logic [31:0] d1);
      logic [31:0] e_f0, e_f1;
      logic [4:0]  ga;
      logic [31:0] gd;
      bit          st;
      hold = h; clr_stats = c;
      req0_valid = v0; req0_addr = a0; req0_data = d0;
      req1_valid = v1; req1_addr = a1; req1_data = d1;
      if (use_mem) begin
         rf_rd_data0 = rf_mem[rd_addr0];
         rf_rd_data1 = rf_mem[rd_addr1];
      end
      #1;
      exp_g = -1;
      if (!h) begin
         if (v0 && v1) exp_g = (m_last == 0) ? 1 : 0;
         else if (v0) exp_g = 0;
         else if (v1) exp_g = 1;
      end
      st = (v0 && exp_g != 0) || (v1 && exp_g != 1);
      e_f0 = (m_ena && m_addr == rd_addr0 && rd_addr0 != 0) ? m_data : rf_rd_data0;
      e_f1 = (m_ena && m_addr == rd_addr1 && rd_addr1 != 0) ? m_data : rf_rd_data1;
      check("req0_ready", {31'd0, req0_ready}, {31'd0, exp_g == 0});
      check("req1_ready", {31'd0, req1_ready}, {31'd0, exp_g == 1});
      check("wr_ena", {31'd0, wr_ena}, {31'd0, m_ena});
      check("wr_addr", {27'd0, wr_addr}, {27'd0, m_addr});
      check("wr_data", wr_data, m_data);
      check("fwd_data0", fwd_data0, e_f0);
      check("fwd_data1", fwd_data1, e_f1);
      check("stall_count", {28'd0, stall_count}, 32'(m_stall));
      @(posedge clk);
      if (m_ena) rf_mem[m_addr] = m_data;
      if (exp_g >= 0) begin
         ga = (exp_g == 0) ? a0 : a1;
         gd = (exp_g == 0) ? d0 : d1;
         m_last = exp_g;
         m_ena  = (ga != 5'd0);
         if (ga != 5'd0) begin
            m_addr = ga;
            m_data = gd;
         end
      end else begin
         m_ena = 1'b0;
      end
      if (c) m_stall = 0;
      else if (st && m_stall < CNT_MAX) m_stall = m_stall + 1;
      @(negedge clk);
   endtask

   task automatic idle();
      step(0, 0, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
   endtask

   initial begin
      logic        p0, p1;
      logic [4:0]  pa0, pa1;
      logic [31:0] pd0, pd1;

      for (int i = 0; i < 32; i++) rf_mem[i] = 32'd0;
      model_reset();
      @(negedge clk);
      do_reset();

      // Single request from req0.
      step(0, 0, 1, 5'd5, 32'h1234, 0, 5'd0, 32'd0);
      check("tp_single_ena", {31'd0, wr_ena}, 32'd1);
      check("tp_single_addr", {27'd0, wr_addr}, 32'd5);
      check("tp_single_data", wr_data, 32'h0000_1234);
      idle();
      check("tp_single_done", {31'd0, wr_ena}, 32'd0);

      // Sustained contention: alternating grants, one stalled requester per cycle.
      do_reset();
      for (int i = 0; i < 4; i++) step(0, 0, 1, 5'd1, 32'h100 + i, 1, 5'd2, 32'h200 + i);
      check("tp_rr_stall", {28'd0, stall_count}, 32'd4);
      check("tp_rr_last_addr", {27'd0, wr_addr}, 32'd2);
      idle();

      // x0 write from req1 is accepted but dropped; the next tie then goes to req0.
      do_reset();
      step(0, 0, 0, 5'd0, 32'd0, 1, 5'd0, 32'hDEAD);
      check("tp_x0_ena", {31'd0, wr_ena}, 32'd0);
      step(0, 0, 1, 5'd3, 32'h33, 1, 5'd4, 32'h44);
      check("tp_x0_tie_addr", {27'd0, wr_addr}, 32'd3);
      idle();

      // Forwarding of the write being committed; x0 reads bypass forwarding.
      step(0, 0, 1, 5'd7, 32'hCAFE_F00D, 0, 5'd0, 32'd0);
      rd_addr0 = 5'd7; rd_addr1 = 5'd0; rf_rd_data0 = 32'h11; rf_rd_data1 = 32'h22;
      #1;
      check("tp_fwd0", fwd_data0, 32'hCAFE_F00D);
      check("tp_fwd1", fwd_data1, 32'h22);
      idle();
      check("tp_fwd0_after", fwd_data0, 32'h11);

      // Hold blocks grants and counts stalls; clear wins over increment.
      do_reset();
      for (int i = 0; i < 3; i++) step(1, 0, 1, 5'd6, 32'h66, 0, 5'd0, 32'd0);
      check("tp_hold_stall", {28'd0, stall_count}, 32'd3);
      step(0, 0, 1, 5'd6, 32'h66, 0, 5'd0, 32'd0);
      step(1, 1, 1, 5'd8, 32'h88, 0, 5'd0, 32'd0);
      check("tp_clr_stall", {28'd0, stall_count}, 32'd0);

      // Saturation and asynchronous reset with a write in flight.
      do_reset();
      for (int i = 0; i < 20; i++) step(1, 0, 1, 5'd9, 32'h99, 0, 5'd0, 32'd0);
      check("tp_sat", {28'd0, stall_count}, 32'hF);
      step(0, 0, 1, 5'd9, 32'h99, 0, 5'd0, 32'd0);
      check("tp_pre_rst_ena", {31'd0, wr_ena}, 32'd1);
      req0_valid = 1'b0;
      rst = 1'b0;
      #1;
      check("tp_async_rst_ena", {31'd0, wr_ena}, 32'd0);
      check("tp_async_rst_stall", {28'd0, stall_count}, 32'd0);
      @(negedge clk);
      rst = 1'b1;
      model_reset();
      @(negedge clk);

      // Randomized traffic; requesters keep addr/data stable until accepted.
      use_mem = 1'b1;
      p0 = 1'b0; p1 = 1'b0; pa0 = '0; pa1 = '0; pd0 = '0; pd1 = '0;
      for (int n = 0; n < 400; n++) begin
         if (!p0 && $urandom_range(0, 99) < 60) begin
            p0 = 1'b1; pa0 = 5'($urandom_range(0, 7)); pd0 = $urandom;
         end
         if (!p1 && $urandom_range(0, 99) < 60) begin
            p1 = 1'b1; pa1 = 5'($urandom_range(0, 7)); pd1 = $urandom;
         end
         rd_addr0 = 5'($urandom_range(0, 7));
         rd_addr1 = 5'($urandom_range(0, 7));
         step($urandom_range(0, 99) < 10, $urandom_range(0, 99) < 5,
              p0, pa0, pd0, p1, pa1, pd1);
         if (exp_g == 0) p0 = 1'b0;
         if (exp_g == 1) p1 = 1'b0;
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the register file's single write channel between two writeback requesters: req0 (ALU/execute result) and req1 (load/memory result).
- Uses round-robin arbitration with a valid/ready handshake per requester.
- Registers the granted write into a one-stage output that drives the register file's wr_ena/wr_addr/wr_data.
- Provides same-cycle read forwarding so readers see the write currently being committed, and keeps a saturating count of arbitration-lost cycles.

Parameters:
- STALL_CNT_W, 16, width of the saturating stall counter.

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst  input  1  asynchronous active-low reset (0 = reset asserted).
- hold  input  1  when 1, no request is granted this cycle.
- clr_stats  input  1  synchronous clear of stall_count.
- req0_valid  input  1  requester 0 has a write.
- req0_ready  output  1  requester 0 write accepted this cycle.
- req0_addr  input  5  requester 0 destination register.
- req0_data  input  32  requester 0 write data.
- req1_valid  input  1  requester 1 has a write.
- req1_ready  output  1  requester 1 write accepted this cycle.
- req1_addr  input  5  requester 1 destination register.
- req1_data  input  32  requester 1 write data.
- wr_ena  output  1  register file write enable (registered).
- wr_addr  output  5  register file write address (registered).
- wr_data  output  32  register file write data (registered).
- rd_addr0  input  5  read port 0 address, also driven to the register file.
- rd_addr1  input  5  read port 1 address, also driven to the register file.
- rf_rd_data0  input  32  register file read data 0.
- rf_rd_data1  input  32  register file read data 1.
- fwd_data0  output  32  forwarded read data 0.
- fwd_data1  output  32  forwarded read data 1.
- stall_count  output  STALL_CNT_W  cycles in which a valid request was not granted.

Behaviour:
- Reset (rst=0, async): wr_ena=0, wr_addr=0, wr_data=0, last_grant=1 (req0 wins the first tie), stall_count=0.
- Handshake:
  - A transfer occurs when reqN_valid && reqN_ready.
  - reqN_ready is combinational from the valids, hold and last_grant.
  - At most one ready is high per cycle; ready is never high without the matching valid.
  - Requesters hold addr/data stable while valid && !ready.
- Arbitration when hold=0:
  - Only one valid: grant it.
  - Both valid: grant the requester not equal to last_grant.
  - last_grant updates to the granted index on every grant.
- Arbitration when hold=1: both readies are 0, last_grant is unchanged, wr_ena is 0 next cycle.
- Output stage, one-cycle latency (write hits the register file on the edge after wr_ena is seen high):
  - On a grant with addr≠0: next cycle wr_ena=1, wr_addr/wr_data = granted addr/data.
  - On a grant with addr=0: the request is accepted (ready=1, last_grant updates) but wr_ena=0 next cycle; x0 writes are dropped.
  - No grant: wr_ena=0 next cycle; wr_addr/wr_data hold their previous values.
- Same address from both requesters in the same cycle: the writes are serialized in grant order, and the later grant's value persists.
- Back-to-back grants are allowed every cycle, giving sustained throughput of 1 write/cycle.
- Forwarding (combinational):
  - fwd_dataK = wr_data if wr_ena && wr_addr==rd_addrK && rd_addrK≠0; otherwise fwd_dataK = rf_rd_dataK.
  - Reads of x0 are never forwarded.
- stall_count:
  - +1 on each cycle where (req0_valid && !req0_ready) || (req1_valid && !req1_ready), including hold cycles.
  - Saturates at all-ones with no wrap.
  - clr_stats=1 forces it to 0 that cycle; clear takes priority over increment.
- Reset mid-operation: the in-flight output write is discarded (wr_ena=0 immediately). Requesters must re-present after rst deasserts.

Test Plan:
- Reset, then req0 valid addr=5 data=0x1234 alone → req0_ready=1 same cycle; next cycle wr_ena=1, wr_addr=5, wr_data=0x00001234; following cycle wr_ena=0.
- Both valid for 4 cycles (req0 addr=1, req1 addr=2) → grants alternate 0,1,0,1 from reset; stall_count=4 after 4 cycles; wr_addr sequence 1,2,1,2.
- req1 valid addr=0 data=0xDEAD → req1_ready=1, wr_ena stays 0, last_grant=1 (next tie goes to req0).
- Write addr=7 data=0xCAFEF00D with rd_addr0=7, rd_addr1=0, rf_rd_data0=0x11, rf_rd_data1=0x22 → while wr_ena=1: fwd_data0=0xCAFEF00D, fwd_data1=0x22.
- hold=1 for 3 cycles with req0 valid → req0_ready=0, wr_ena=0, stall_count=3; then hold=0 → granted, and clr_stats gives stall_count=0 next cycle.
- Force stall_count near max (STALL_CNT_W=4, 20 stalled cycles) → holds at 0xF; asserting rst while wr_ena=1 → wr_ena=0 immediately.
